sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning SRAM data, MAR and MDR width; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 18, meaning SRAM address width; ADDR_W >= DATA_W is required.
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning extra ACCESS cycles per transfer; legal range is 0..15.
REQ-004 SHALL have port clock, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-006 SHALL have port reg_be, input, width DATA_W/8: per-byte register load enable, replacing the fixed ub/lb pair.
REQ-007 SHALL have port reg_sel, input, width 1: 1 selects MAR, 0 selects MDR, for both reg_q and register loads.
REQ-008 SHALL have port reg_d, input, width DATA_W: register load data.
REQ-009 SHALL have port reg_q, output, width DATA_W: selected register value.
REQ-010 SHALL have ports req_read and req_write, input, width 1 each: access requests, sampled only in IDLE.
REQ-011 SHALL have port acc_be, input, width DATA_W/8: write byte-lane enables, captured with req_write.
REQ-012 SHALL have ports busy and done, output, width 1 each: busy means not in IDLE; done is a one-cycle completion pulse.
REQ-013 SHALL have ports ram_ce_n, ram_oe_n and ram_we_n, output, width 1 each: active-low SRAM strobes.
REQ-014 SHALL have ports ram_be_n, output, width DATA_W/8; ram_a, output, width ADDR_W; ram_d, inout, width DATA_W.

Function
REQ-015 SHALL implement an FSM with states IDLE, SETUP, ACCESS and DONE.
REQ-016 SHALL sequence every transfer as IDLE -> SETUP (1 cycle) -> ACCESS (WAIT_STATES+1 cycles, counted by a wait counter) -> DONE (1 cycle) -> IDLE.
REQ-017 SHALL, for a request sampled at edge N, assert done during cycle N+3+WAIT_STATES; busy is high from N+1 through the DONE cycle.
REQ-018 SHALL, when req_read and req_write are both high in IDLE, perform the write and drop the read.
REQ-019 SHALL ignore requests that arrive while busy.
REQ-020 SHALL, in IDLE only, load the register chosen by reg_sel byte-wise: lanes with reg_be=1 take reg_d and the other lanes hold; loads while busy are ignored.
REQ-021 SHALL drive ram_a as MAR zero-extended to ADDR_W.
REQ-022 SHALL hold ram_ce_n low only from SETUP through DONE, and high in IDLE.
REQ-023 SHALL, on a read, drive ram_oe_n low in SETUP and ACCESS, and ram_be_n all 0.
REQ-024 SHALL, on a read, load all MDR lanes from ram_d on the last ACCESS cycle.
REQ-025 SHALL, on a write, drive ram_d from MDR during SETUP, ACCESS and DONE, and tri-state ram_d otherwise.
REQ-026 SHALL, on a write, drive ram_we_n low only during ACCESS and ram_be_n = ~captured acc_be; ram_oe_n stays high.
REQ-027 SHALL, in IDLE, drive every strobe and ram_be_n high.

Reset
REQ-028 SHALL, on reset at any clock edge including mid-transfer, next cycle: FSM = IDLE; MAR, MDR and wait counter = 0; busy and done = 0; all strobes high; ram_d = Z; reg_q = 0.

Configuration
REQ-029 SHALL, with SRAM_CTRL_AUTOINC_EN defined, increment MAR by 1 in the DONE cycle of every transfer, wrapping from all-ones to 0.
REQ-030 SHALL, without SRAM_CTRL_AUTOINC_EN, leave MAR unchanged by transfers.

Structure
REQ-031 SHALL take the state enum sram_state_t and a WAIT_MAX=15 constant from a shared package sram_pkg.
REQ-032 SHALL instantiate MAR and MDR as two copies of a sub-module be_reg: a DATA_W register with per-byte load enables and synchronous reset.

Verification
REQ-033 SHALL cover: reg_sel=1, reg_be=2'b11, reg_d=0x0123 -> reg_q=0x0123 and ram_a=0x00123.
REQ-034 SHALL cover: MDR=0xBEEF, acc_be=2'b01, req_write with WAIT_STATES=1 -> ram_we_n low 2 cycles, ram_be_n=2'b10, done at N+4.
REQ-035 SHALL cover: SRAM model returns 0xA55A, req_read -> MDR=0xA55A and done at N+3+WAIT_STATES; with AUTOINC, MAR 0xFFFF -> 0x0000.
REQ-036 SHALL cover: req_read and req_write high together in IDLE -> write performed; a req_read during busy -> ignored.
REQ-037 SHALL cover: reset asserted in ACCESS -> next cycle all strobes high, ram_d=Z, busy=0, MAR=MDR=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding and wait-state limit.
package sram_pkg;

    localparam int WAIT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } sram_state_t;

endpackage

// File: rtl/sram_ctrl_be_reg.sv
// be_reg: DATA_W-wide register with per-byte load enables and synchronous active-high reset.
module be_reg #(
    parameter int DATA_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   d,
    output logic [DATA_W-1:0]   q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    q[i*8 +: 8] <= d[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous SRAM controller with MAR/MDR registers and a SETUP/ACCESS/DONE sequence.
// Optional feature: define SRAM_CTRL_AUTOINC_EN to post-increment MAR after every transfer.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W/8-1:0] reg_be,
    input  logic                reg_sel,
    input  logic [DATA_W-1:0]   reg_d,
    output logic [DATA_W-1:0]   reg_q,
    input  logic                req_read,
    input  logic                req_write,
    input  logic [DATA_W/8-1:0] acc_be,
    output logic                busy,
    output logic                done,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic [DATA_W/8-1:0] ram_be_n,
    output logic [ADDR_W-1:0]   ram_a,
    inout  wire  [DATA_W-1:0]   ram_d
);

    localparam int NB  = DATA_W / 8;
    localparam int WCW = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_STATES);

    sram_state_t    state;
    logic [WCW-1:0] wait_cnt;
    logic           is_write;
    logic [NB-1:0]  be_cap;

    logic [DATA_W-1:0] mar_q, mdr_q, mar_d, mdr_d;
    logic [NB-1:0]     mar_be, mdr_be;
    logic              idle, last_access;

    assign idle        = (state == IDLE);
    assign last_access = (state == ACCESS) && (wait_cnt == WAIT_LAST);

    // Reads capture all-ones lanes so the inverted value gives ram_be_n = 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            is_write <= 1'b0;
            be_cap   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_write || req_read) begin
                        state    <= SETUP;
                        is_write <= req_write;
                        be_cap   <= req_write ? acc_be : '1;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (last_access) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Host loads only land in IDLE, so they never collide with read capture or auto-increment.
    always_comb begin
        mar_be = '0;
        mar_d  = reg_d;
        mdr_be = '0;
        mdr_d  = reg_d;
        if (idle) begin
            if (reg_sel) begin
                mar_be = reg_be;
            end else begin
                mdr_be = reg_be;
            end
        end
        if (last_access && !is_write) begin
            mdr_be = '1;
            mdr_d  = ram_d;
        end
`ifdef SRAM_CTRL_AUTOINC_EN
        if (state == DONE) begin
            mar_be = '1;
            mar_d  = mar_q + DATA_W'(1);
        end
`else
`endif
    end

    be_reg #(.DATA_W(DATA_W)) u_mar (
        .clock (clock),
        .reset (reset),
        .be    (mar_be),
        .d     (mar_d),
        .q     (mar_q)
    );

    be_reg #(.DATA_W(DATA_W)) u_mdr (
        .clock (clock),
        .reset (reset),
        .be    (mdr_be),
        .d     (mdr_d),
        .q     (mdr_q)
    );

    always_comb begin
        ram_a              = '0;
        ram_a[DATA_W-1:0]  = mar_q;
    end

    assign reg_q    = reg_sel ? mar_q : mdr_q;
    assign busy     = !idle;
    assign done     = (state == DONE);
    assign ram_ce_n = idle;
    assign ram_oe_n = is_write || !((state == SETUP) || (state == ACCESS));
    assign ram_we_n = !(is_write && (state == ACCESS));
    assign ram_be_n = idle ? '1 : ~be_cap;
    assign ram_d    = (is_write && !idle) ? mdr_q : 'z;

endmodule
